// File: rtl/up_dn_counter_driver.sv
// Command-side driver for a saturating up/down counter: optional preload, then steps toward Target.
// Optional Steps output (command-cycle count) enabled by defining UP_DN_DRIVER_STEP_COUNT_EN.
module up_dn_counter_driver #(
    parameter int WIDTH   = 5,
    parameter int TIMEOUT = 40
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] Target,
    input  logic             Use_Load,
    input  logic [WIDTH-1:0] Load_Val,
    input  logic [WIDTH-1:0] Counter,
    input  logic             High,
    input  logic             Low,
    output logic [WIDTH-1:0] IN,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic             Busy,
    output logic             Done,
    output logic             Err
`ifdef UP_DN_DRIVER_STEP_COUNT_EN
    ,
    output logic [WIDTH:0]   Steps
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] target_q, load_val_q;
    logic             use_load_q;
    logic             err_q, err_nx;
    logic [TW-1:0]    timer_q;
    logic             accept;

    assign accept = (state == IDLE) && Start;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            err_q      <= 1'b0;
            target_q   <= '0;
            load_val_q <= '0;
            use_load_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (accept) begin
                target_q   <= Target;
                load_val_q <= Load_Val;
                use_load_q <= Use_Load;
            end
            // Timer only runs while stepping, so it is zero on every STEP entry.
            if (state == STEP) timer_q <= timer_q + 1'b1;
            else               timer_q <= '0;
        end
    end

    always_comb begin
        state_nx = state;
        err_nx   = err_q;
        IN       = '0;
        Load     = 1'b0;
        Up       = 1'b0;
        Down     = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        Err      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nx = Use_Load ? LOAD : STEP;
                    err_nx   = 1'b0;
                end
            end
            LOAD: begin
                Load     = 1'b1;
                IN       = load_val_q;
                Busy     = 1'b1;
                state_nx = STEP;
            end
            STEP: begin
                Busy = 1'b1;
                if (Counter == target_q) begin
                    state_nx = DONE;
                    err_nx   = 1'b0;
                end else begin
                    if (Counter < target_q) begin
                        Up = 1'b1;
                        if (High) begin
                            state_nx = DONE;
                            err_nx   = 1'b1;
                        end
                    end else begin
                        Down = 1'b1;
                        if (Low) begin
                            state_nx = DONE;
                            err_nx   = 1'b1;
                        end
                    end
                    if (timer_q == TLAST) begin
                        state_nx = DONE;
                        err_nx   = 1'b1;
                    end
                end
            end
            DONE: begin
                Done     = 1'b1;
                Err      = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef UP_DN_DRIVER_STEP_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST)            Steps <= '0;
        else if (accept)    Steps <= '0;
        else if (Up || Down) Steps <= Steps + 1'b1;
    end
`endif

endmodule

// File: tb/tb_up_dn_counter_driver.sv
// Directed bench for up_dn_counter_driver: a saturating counter model closes the loop on one
// instance; a second instance with TIMEOUT=8 sees a stuck counter value.
module tb_up_dn_counter_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, use_load;
    logic [4:0] target, load_val;
    logic [4:0] cnt;
    logic       high, low;
    logic [4:0] in;
    logic       load, up, down, busy, done, err;

    logic       start2;
    logic [4:0] target2;
    logic       use_load2;
    logic [4:0] load_val2;
    logic [4:0] stuck_cnt;
    logic       stuck_high, stuck_low;
    logic [4:0] in2;
    logic       load2, up2, down2, busy2, done2, err2;

    logic       preset_en;
    logic [4:0] preset_val;

    int checks = 0;
    int errors = 0;

`ifdef UP_DN_DRIVER_STEP_COUNT_EN
    logic [5:0] steps, steps2;
`endif

    always #5 clk = ~clk;

    up_dn_counter_driver dut (
        .CLK(clk), .RST(rst), .Start(start), .Target(target), .Use_Load(use_load),
        .Load_Val(load_val), .Counter(cnt), .High(high), .Low(low),
        .IN(in), .Load(load), .Up(up), .Down(down), .Busy(busy), .Done(done), .Err(err)
`ifdef UP_DN_DRIVER_STEP_COUNT_EN
        , .Steps(steps)
`endif
    );

    up_dn_counter_driver #(.WIDTH(5), .TIMEOUT(8)) dut_to (
        .CLK(clk), .RST(rst), .Start(start2), .Target(target2), .Use_Load(use_load2),
        .Load_Val(load_val2), .Counter(stuck_cnt), .High(stuck_high), .Low(stuck_low),
        .IN(in2), .Load(load2), .Up(up2), .Down(down2), .Busy(busy2), .Done(done2), .Err(err2)
`ifdef UP_DN_DRIVER_STEP_COUNT_EN
        , .Steps(steps2)
`endif
    );

    // Saturating counter: Load first, then Down over Up; preset is a bench-only backdoor.
    always_ff @(posedge clk) begin
        if (rst)                 cnt <= '0;
        else if (preset_en)      cnt <= preset_val;
        else if (load)           cnt <= in;
        else if (down)           begin if (cnt != 5'd0)  cnt <= cnt - 5'd1; end
        else if (up)             begin if (cnt != 5'd31) cnt <= cnt + 5'd1; end
    end
    assign high = (cnt == 5'd31);
    assign low  = (cnt == 5'd0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [4:0] v);
        preset_en  = 1'b1;
        preset_val = v;
        tick;
        preset_en  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1; use_load = 1'b1; load_val = 5'd7; target = 5'd3;
        start2 = 1'b1; target2 = 5'd10;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if ({in, load, up, down, busy, done, err} !== 12'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b expected 0", i,
                         {in, load, up, down, busy, done, err});
            end
            checks++;
            if ({in2, load2, up2, down2, busy2, done2, err2} !== 12'd0) begin
                errors++;
                $display("FAIL reset_outputs_to[%0d]: got %b expected 0", i,
                         {in2, load2, up2, down2, busy2, done2, err2});
            end
        end
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_up_move;
        int ups, downs, loads, done_at;
        logic errv;
        ups = 0; downs = 0; loads = 0; done_at = 0; errv = 1'bx;
        preset(5'd0);
        start = 1'b1; use_load = 1'b1; load_val = 5'd16; target = 5'd20;
        tick;
        start = 1'b0;
        checks++;
        if (load !== 1'b1 || in !== 5'd16 || up !== 1'b0 || down !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL up_load_cycle: got load=%b in=%0d up=%b down=%b busy=%b expected 1 16 0 0 1",
                     load, in, up, down, busy);
        end
        for (int c = 2; c <= 7; c++) begin
            tick;
            if (up) ups++;
            if (down) downs++;
            if (load) loads++;
            if (done && done_at == 0) begin done_at = c; errv = err; end
        end
        checks++;
        if (ups != 4 || downs != 0 || loads != 0) begin
            errors++;
            $display("FAIL up_commands: got up=%0d down=%0d load=%0d expected 4 0 0", ups, downs, loads);
        end
        checks++;
        if (done_at != 7 || errv !== 1'b0) begin
            errors++;
            $display("FAIL up_done: got cycle=%0d err=%b expected cycle 7 err 0", done_at, errv);
        end
        checks++;
        if (cnt !== 5'd20) begin
            errors++;
            $display("FAIL up_final_count: got %0d expected 20", cnt);
        end
`ifdef UP_DN_DRIVER_STEP_COUNT_EN
        tick;
        checks++;
        if (steps !== 6'd4) begin
            errors++;
            $display("FAIL up_steps: got %0d expected 4", steps);
        end
`else
        tick;
`endif
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL up_back_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_down_move;
        int ups, downs, both;
        logic got;
        logic errv;
        ups = 0; downs = 0; both = 0; got = 1'b0; errv = 1'bx;
        preset(5'd31);
        start = 1'b1; use_load = 1'b0; load_val = 5'd0; target = 5'd0;
        tick;
        start = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (up) ups++;
            if (down) downs++;
            if (up && down) both++;
            if (done) begin got = 1'b1; errv = err; end
            else tick;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL down_timeout: got no Done within 60 cycles expected Done");
        end
        checks++;
        if (downs != 31 || ups != 0 || both != 0) begin
            errors++;
            $display("FAIL down_commands: got down=%0d up=%0d both=%0d expected 31 0 0", downs, ups, both);
        end
        checks++;
        if (errv !== 1'b0 || cnt !== 5'd0) begin
            errors++;
            $display("FAIL down_result: got err=%b cnt=%0d expected 0 0", errv, cnt);
        end
        tick;
    endtask

    task automatic test_already_equal;
        preset(5'd9);
        start = 1'b1; use_load = 1'b0; target = 5'd9;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || up !== 1'b0 || down !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL equal_step: got busy=%b up=%b down=%b load=%b done=%b expected 1 0 0 0 0",
                     busy, up, down, load, done);
        end
        tick;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL equal_done: got done=%b err=%b busy=%b expected 1 0 0", done, err, busy);
        end
`ifdef UP_DN_DRIVER_STEP_COUNT_EN
        checks++;
        if (steps !== 6'd0) begin
            errors++;
            $display("FAIL equal_steps: got %0d expected 0", steps);
        end
`endif
        // Start held across the DONE edge must not launch a new request.
        start = 1'b1; target = 5'd3;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || down !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_ignored: got busy=%b down=%b done=%b expected 0 0 0",
                     busy, down, done);
        end
        tick;
    endtask

    task automatic test_timeout;
        int ups, downs;
        logic got;
        logic errv;
        ups = 0; downs = 0; got = 1'b0; errv = 1'bx;
        start2 = 1'b1; target2 = 5'd10; use_load2 = 1'b0;
        tick;
        for (int c = 0; c < 30 && !got; c++) begin
            start2 = (c < 3);
            if (up2) ups++;
            if (down2) downs++;
            if (done2) begin got = 1'b1; errv = err2; end
            else tick;
        end
        start2 = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout_no_done: got no Done within 30 cycles expected Done");
        end
        checks++;
        if (ups != 8 || downs != 0) begin
            errors++;
            $display("FAIL timeout_commands: got up=%0d down=%0d expected 8 0", ups, downs);
        end
        checks++;
        if (errv !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: got %b expected 1", errv);
        end
`ifdef UP_DN_DRIVER_STEP_COUNT_EN
        checks++;
        if (steps2 !== 6'd8) begin
            errors++;
            $display("FAIL timeout_steps: got %0d expected 8", steps2);
        end
`endif
        tick;
        tick;
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle_after: got busy=%b done=%b expected 0 0", busy2, done2);
        end
    endtask

    task automatic test_reset_mid_op;
        int dones;
        logic got;
        logic errv;
        dones = 0; got = 1'b0; errv = 1'bx;
        preset(5'd0);
        start = 1'b1; use_load = 1'b1; load_val = 5'd16; target = 5'd20;
        tick;
        start = 1'b0;
        tick;
        tick;
        checks++;
        if (up !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_stepping: got up=%b busy=%b expected 1 1", up, busy);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (up !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got up=%b busy=%b done=%b expected 0 0 0", up, busy, done);
        end
        for (int c = 0; c < 8; c++) begin
            tick;
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midrst_quiet: got %0d active cycles expected 0", dones);
        end
        start = 1'b1; use_load = 1'b1; load_val = 5'd16; target = 5'd20;
        tick;
        start = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done) begin got = 1'b1; errv = err; end
            else tick;
        end
        checks++;
        if (!got || errv !== 1'b0 || cnt !== 5'd20) begin
            errors++;
            $display("FAIL midrst_restart: got done=%b err=%b cnt=%0d expected 1 0 20", got, errv, cnt);
        end
        tick;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; use_load = 1'b0; target = '0; load_val = '0;
        start2 = 1'b0; target2 = '0; use_load2 = 1'b0; load_val2 = '0;
        stuck_cnt = 5'd5; stuck_high = 1'b0; stuck_low = 1'b0;
        preset_en = 1'b0; preset_val = '0;
        #2;
        test_reset;
        test_up_move;
        test_down_move;
        test_already_equal;
        test_timeout;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_dn_counter_driver.md
Name: up_dn_counter_driver

Overview:
- Command-side initiator for the 5-bit up/down counter.
- Accepts a "move to target" request and optionally preloads the counter.
- Drives the counter's IN/Load/Up/Down inputs and watches its Counter/High/Low outputs until Counter equals Target or a timeout expires.
- Sits between the control logic and the counter instance; it is the only source of the counter's command inputs.

Parameters:
- WIDTH, 5, data width of Target, Load_Val, IN and Counter
- TIMEOUT, 40, max STEP-state cycles before the request is aborted with Err (>=1)

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST  input  1  synchronous active-high reset
- Start  input  1  request strobe, sampled only in IDLE
- Target  input  WIDTH  destination count, latched on accepted Start
- Use_Load  input  1  1 = preload Load_Val before stepping, latched on Start
- Load_Val  input  WIDTH  preload value, latched on Start
- Counter  input  WIDTH  counter's current value
- High  input  1  counter at max (all ones)
- Low  input  1  counter at zero
- IN  output  WIDTH  preload value to counter
- Load  output  1  counter load command
- Up  output  1  counter increment command
- Down  output  1  counter decrement command
- Busy  output  1  request in progress (LOAD or STEP)
- Done  output  1  one-cycle completion pulse
- Err  output  1  valid with Done; 1 = request failed

Behaviour:
- Counter contract: Load has priority, then Down over Up. The counter saturates at 0/all-ones. Its update is registered and visible the cycle after the command edge.
- FSM states: IDLE, LOAD, STEP, DONE. State and latched registers are held in flops.
- Output decode: Load/Up/Down/IN/Busy/Done/Err are decoded combinationally from state, latched values and Counter.
- Reset: on RST=1 at an edge, the next state is IDLE and all latches and timers clear. Outputs IN=0, Load=0, Up=0, Down=0, Busy=0, Done=0, Err=0. Reset mid-request aborts it with no Done.
- IDLE: Start=1 latches Target, Use_Load and Load_Val. The next state is LOAD if Use_Load, else STEP. Start is ignored in all other states.
- LOAD: lasts one cycle. Load=1 and IN=latched Load_Val; Up=Down=0. Next state is STEP.
- STEP:
  - If Counter==Target: next state DONE with error flag 0; no command.
  - Else if Counter<Target: Up=1. If High=1, next state DONE with error flag 1.
  - Else (Counter>Target): Down=1. If Low=1, next state DONE with error flag 1.
  - A timer counts STEP cycles. If it reaches TIMEOUT without a match, next state is DONE with error flag 1. The timer clears on entry to STEP.
- DONE: lasts one cycle. Done=1 and Err=error flag. Next state is IDLE. A Start during DONE is ignored.
- Busy=1 exactly in LOAD and STEP.
- Up and Down are never high in the same cycle. Load is never high outside LOAD.
- IN=0 when not in LOAD.
- Comparisons are unsigned, WIDTH bits. The timer width is clog2(TIMEOUT+1).
- Counter already equal to Target on STEP entry: one STEP cycle with no command, then DONE, Err=0.

Optional Feature:
- Macro: UP_DN_DRIVER_STEP_COUNT_EN.
- Defined: adds output port Steps (WIDTH+1 bits). It clears on accepted Start, increments on every cycle with Up or Down high, and holds its value after DONE until the next accepted Start. Reset value is 0.
- Undefined: no Steps port and no associated logic.

Test Plan:
- Reset: hold RST=1 for 2 cycles with Start=1 -> all outputs 0, state IDLE; Start is not accepted until RST falls.
- Up move: counter model at 0, Start with Use_Load=1, Load_Val=16, Target=20 -> Load=1 for 1 cycle with IN=16, then Up=1 for 4 cycles (Counter 16..19). Done=1, Err=0 in the 7th cycle after Start is sampled. Steps=4 if UP_DN_DRIVER_STEP_COUNT_EN.
- Down move: no load, Counter=31, Target=0 -> Down=1 for 31 cycles, Up never asserted, then Done=1, Err=0.
- Already equal: Counter=9, Target=9, Use_Load=0 -> one STEP cycle with no command, then Done=1, Err=0, Steps=0.
- Timeout: counter input held at 5 (counter not connected), TIMEOUT=8, Target=10 -> Up=1 for 8 cycles, then Done=1, Err=1. A second Start pulse during Busy is ignored.
- Reset mid-operation: assert RST during STEP of a 16->20 move -> the next cycle shows Up=0, Busy=0, no Done pulse. A fresh Start afterwards completes normally.
